echo_indication_p2m: RTL and testbench

Receive-side decoder for the EchoIndication pipe. It accepts 128-bit pipe words carrying serialized `heard`, `heard2` and `heard3` indications and replays each word as exactly one method call on the matching output method. It has a 2-entry input buffer so the pipe can keep streaming while a method target stalls. It counts malformed words, which are dropped.

---
 rtl/echo_indication_p2m.sv | 145 ++++++++++++++
 tb/tb_echo_indication_p2m.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/echo_indication_p2m.sv
// echo_indication_p2m: receive-side decoder for the EchoIndication pipe.
// A 2-entry FIFO holds raw 128-bit pipe words. The head word is decoded and
// issued as exactly one heard/heard2/heard3 call when its target is ready.
// Malformed words are dropped in one cycle.
// Optional feature macro: ECHO_P2M_ERRCNT_EN. When it is defined, a saturating
// malformed-word counter is built. Otherwise err_count is tied to 0.
module echo_indication_p2m #(
    parameter int unsigned ERR_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pipe_enq__ENA,
    input  logic [127:0]      pipe_enq_v,
    output logic              pipe_enq__RDY,
    output logic              method_heard__ENA,
    output logic [31:0]       method_heard_v,
    input  logic              method_heard__RDY,
    output logic              method_heard2__ENA,
    output logic [15:0]       method_heard2_a,
    output logic [15:0]       method_heard2_b,
    input  logic              method_heard2__RDY,
    output logic              method_heard3__ENA,
    output logic [15:0]       method_heard3_a,
    output logic [31:0]       method_heard3_b,
    output logic [31:0]       method_heard3_c,
    output logic [15:0]       method_heard3_d,
    input  logic              method_heard3__RDY,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned WORD_W = 128;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;

    logic [WORD_W-1:0] buf_q [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [WORD_W-1:0] head;
    logic              head_valid;
    logic [15:0]       head_len;
    logic [15:0]       head_idx;
    logic              is_heard;
    logic              is_heard2;
    logic              is_heard3;
    logic              malformed;
    logic              enq;
    logic              pop;

    assign head       = buf_q[rd_ptr];
    assign head_valid = (count != CNT_W'(0));
    assign head_len   = head[15:0];
    assign head_idx   = head[31:16];

    // Ready depends only on registered occupancy, never on this cycle's pops.
    assign pipe_enq__RDY = (count < CNT_W'(DEPTH));
    assign enq           = pipe_enq__ENA && pipe_enq__RDY;

    // Classify the head word and issue at most one method call.
    always_comb begin
        is_heard           = 1'b0;
        is_heard2          = 1'b0;
        is_heard3          = 1'b0;
        malformed          = 1'b0;
        pop                = 1'b0;
        method_heard__ENA  = 1'b0;
        method_heard2__ENA = 1'b0;
        method_heard3__ENA = 1'b0;
        method_heard_v     = '0;
        method_heard2_a    = '0;
        method_heard2_b    = '0;
        method_heard3_a    = '0;
        method_heard3_b    = '0;
        method_heard3_c    = '0;
        method_heard3_d    = '0;

        is_heard  = (head_idx == 16'd0) && (head_len == 16'd2);
        is_heard2 = (head_idx == 16'd1) && (head_len == 16'd2);
        is_heard3 = (head_idx == 16'd2) && (head_len == 16'd4);
        malformed = head_valid && !(is_heard || is_heard2 || is_heard3);

        method_heard__ENA  = head_valid && is_heard  && method_heard__RDY;
        method_heard2__ENA = head_valid && is_heard2 && method_heard2__RDY;
        method_heard3__ENA = head_valid && is_heard3 && method_heard3__RDY;

        if (method_heard__ENA) begin
            method_heard_v = head[63:32];
        end
        if (method_heard2__ENA) begin
            method_heard2_a = head[47:32];
            method_heard2_b = head[63:48];
        end
        if (method_heard3__ENA) begin
            method_heard3_a = head[47:32];
            method_heard3_b = head[79:48];
            method_heard3_c = head[111:80];
            method_heard3_d = head[127:112];
        end

        pop = malformed || method_heard__ENA || method_heard2__ENA || method_heard3__ENA;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (enq) begin
                buf_q[wr_ptr] <= pipe_enq_v;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ECHO_P2M_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    // Saturating count of dropped malformed words.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= '0;
        end else if (malformed && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_echo_indication_p2m.sv
// Self-checking bench for echo_indication_p2m. It uses directed and randomized
// steps, and a queue-based reference model of the pipe buffer.
module tb_echo_indication_p2m;

    localparam int unsigned ERR_W = 16;

    logic              clk;
    logic              rst;
    logic              enq_ena;
    logic [127:0]      enq_v;
    logic              enq_rdy;
    logic              h_ena;
    logic [31:0]       h_v;
    logic              h_rdy;
    logic              h2_ena;
    logic [15:0]       h2_a;
    logic [15:0]       h2_b;
    logic              h2_rdy;
    logic              h3_ena;
    logic [15:0]       h3_a;
    logic [31:0]       h3_b;
    logic [31:0]       h3_c;
    logic [15:0]       h3_d;
    logic              h3_rdy;
    logic [ERR_W-1:0]  err_count;

    int unsigned   passed;
    int unsigned   total;
    int unsigned   failed;
    logic [127:0]  model_q[$];
    longint unsigned err_model;

    echo_indication_p2m #(.ERR_W(ERR_W)) dut (
        .CLK                (clk),
        .RST                (rst),
        .pipe_enq__ENA      (enq_ena),
        .pipe_enq_v         (enq_v),
        .pipe_enq__RDY      (enq_rdy),
        .method_heard__ENA  (h_ena),
        .method_heard_v     (h_v),
        .method_heard__RDY  (h_rdy),
        .method_heard2__ENA (h2_ena),
        .method_heard2_a    (h2_a),
        .method_heard2_b    (h2_b),
        .method_heard2__RDY (h2_rdy),
        .method_heard3__ENA (h3_ena),
        .method_heard3_a    (h3_a),
        .method_heard3_b    (h3_b),
        .method_heard3_c    (h3_c),
        .method_heard3_d    (h3_d),
        .method_heard3__RDY (h3_rdy),
        .err_count          (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(input logic [15:0] idx, input logic [15:0] len);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[31:16] = idx;
        w[15:0]  = len;
        return w;
    endfunction

    function automatic logic [127:0] rand_word();
        int unsigned k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2: return mk_word(16'd0, 16'd2);
            3, 4:    return mk_word(16'd1, 16'd2);
            5, 6:    return mk_word(16'd2, 16'd4);
            7:       return mk_word(16'($urandom_range(0, 2)), 16'($urandom_range(0, 6)));
            default: return mk_word(16'($urandom_range(3, 9)), 16'd2);
        endcase
    endfunction

    // One clock cycle. It is called at a falling edge. It drives the inputs,
    // checks the outputs against the model, and then advances the model
    // across the rising edge.
    task automatic step(input logic ena, input logic [127:0] w, input logic [2:0] rdys);
        logic [127:0] h;
        logic [15:0]  idx;
        logic [15:0]  len;
        bit           hv;
        bit           well;
        bit           e0;
        bit           e1;
        bit           e2;
        bit           do_pop;
        bit           do_acc;
        enq_ena = ena;
        enq_v   = w;
        h_rdy   = rdys[0];
        h2_rdy  = rdys[1];
        h3_rdy  = rdys[2];
        #1;
        hv   = (model_q.size() > 0) && !rst;
        h    = hv ? model_q[0] : '0;
        idx  = h[31:16];
        len  = h[15:0];
        well = ((idx == 0 || idx == 1) && len == 2) || (idx == 2 && len == 4);
        e0   = hv && well && idx == 0 && rdys[0];
        e1   = hv && well && idx == 1 && rdys[1];
        e2   = hv && well && idx == 2 && rdys[2];
        do_pop = hv && (!well || e0 || e1 || e2);
        do_acc = !rst && ena && (model_q.size() < 2);

        chk("enq_rdy", 128'(enq_rdy), 128'(model_q.size() < 2));
        chk("heard_ena", 128'(h_ena), 128'(e0));
        chk("heard_v", 128'(h_v), e0 ? 128'(h[63:32]) : '0);
        chk("heard2_ena", 128'(h2_ena), 128'(e1));
        chk("heard2_a", 128'(h2_a), e1 ? 128'(h[47:32]) : '0);
        chk("heard2_b", 128'(h2_b), e1 ? 128'(h[63:48]) : '0);
        chk("heard3_ena", 128'(h3_ena), 128'(e2));
        chk("heard3_a", 128'(h3_a), e2 ? 128'(h[47:32]) : '0);
        chk("heard3_b", 128'(h3_b), e2 ? 128'(h[79:48]) : '0);
        chk("heard3_c", 128'(h3_c), e2 ? 128'(h[111:80]) : '0);
        chk("heard3_d", 128'(h3_d), e2 ? 128'(h[127:112]) : '0);
`ifdef ECHO_P2M_ERRCNT_EN
        chk("err_count", 128'(err_count), 128'(err_model));
`else
        chk("err_count", 128'(err_count), '0);
`endif

        @(posedge clk);
        if (!rst) begin
            if (do_pop) begin
                if (!well && err_model < ((64'd1 << ERR_W) - 1)) err_model++;
                void'(model_q.pop_front());
            end
            if (do_acc) model_q.push_back(w);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] w1;
        logic [127:0] w2;
        logic [127:0] w3;
        passed    = 0;
        total     = 0;
        failed    = 0;
        err_model = 0;
        rst       = 1'b1;
        enq_ena   = 1'b0;
        enq_v     = '0;
        h_rdy     = 1'b0;
        h2_rdy    = 1'b0;
        h3_rdy    = 1'b0;

        // Reset state. An enqueue attempt during reset is ignored.
        @(negedge clk);
        step(1'b0, '0, 3'b111);
        step(1'b1, mk_word(16'd0, 16'd2), 3'b111);
        rst = 1'b0;
        step(1'b0, '0, 3'b111);

        // heard DEADBEEF with the target ready.
        step(1'b1, {64'h0, 32'hDEADBEEF, 16'h0000, 16'h0002}, 3'b111);
        step(1'b0, '0, 3'b111);
        step(1'b0, '0, 3'b111);

        // heard2 held while its target stalls. Other targets' ready lines are ignored.
        step(1'b1, {64'h0, 16'h5678, 16'h1234, 16'h0001, 16'h0002}, 3'b000);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 3'b101);
        step(1'b0, '0, 3'b010);
        step(1'b0, '0, 3'b111);

        // heard3 exact field placement.
        step(1'b1, {16'hBBBB, 32'h22222222, 32'h11111111, 16'hAAAA, 16'h0002, 16'h0004}, 3'b111);
        step(1'b0, '0, 3'b111);

        // Backpressure: a third word waits for the first pop, and order is kept.
        w1 = mk_word(16'd0, 16'd2);
        w2 = mk_word(16'd1, 16'd2);
        w3 = mk_word(16'd2, 16'd4);
        step(1'b1, w1, 3'b000);
        step(1'b1, w2, 3'b000);
        step(1'b1, w3, 3'b000);
        step(1'b1, w3, 3'b000);
        step(1'b1, w3, 3'b111);
        step(1'b1, w3, 3'b111);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 3'b111);

        // Malformed words: wrong length, then an out-of-range index.
        step(1'b1, mk_word(16'd0, 16'd4), 3'b111);
        step(1'b1, mk_word(16'd7, 16'd2), 3'b111);
        step(1'b0, '0, 3'b111);
        step(1'b0, '0, 3'b111);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rand_word(),
                 {($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0});
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 3'b111);

        // Reset with two words buffered discards them immediately.
        step(1'b1, mk_word(16'd0, 16'd2), 3'b000);
        step(1'b1, mk_word(16'd3, 16'd2), 3'b000);
        rst = 1'b1;
        model_q.delete();
        err_model = 0;
        step(1'b0, '0, 3'b111);
        step(1'b0, '0, 3'b111);
        rst = 1'b0;
        step(1'b0, '0, 3'b111);
        step(1'b0, '0, 3'b111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
